// File: rtl/ex_wb_stage_pkg.sv
// Shared types and widths for the execute-to-writeback stage.
package ex_wb_stage_pkg;

  localparam int RISCV_WORD_WIDTH = 32;
  localparam int XLEN             = RISCV_WORD_WIDTH;
  localparam int REG_ADDR_W       = 5;

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_JAL    = 2'd2,
    KIND_JALR   = 2'd3
  } ex_kind_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  we;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

  // Return address written by JAL/JALR; wraps silently at the top of memory.
  function automatic logic [XLEN-1:0] link_addr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/ex_wb_stage_if.sv
// Execute-side and writeback-side handshake bundle for ex_wb_stage.
// master: the surrounding pipeline (drives ex_*, consumes wb_*).
// slave:  the stage itself.
interface ex_wb_stage_if;
  import ex_wb_stage_pkg::*;

  logic                  ex_valid_i;
  logic                  ex_ready_o;
  logic [XLEN-1:0]       ex_result_i;
  logic [XLEN-1:0]       ex_pc_i;
  logic [XLEN-1:0]       ex_imm_i;
  logic [REG_ADDR_W-1:0] ex_rd_i;
  logic                  ex_rd_we_i;
  logic [1:0]            ex_kind_i;

  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [REG_ADDR_W-1:0] wb_rd_o;
  logic [XLEN-1:0]       wb_data_o;
  logic                  wb_we_o;

  logic                  redirect_o;
  logic [XLEN-1:0]       redirect_pc_o;

  modport master (
    output ex_valid_i, ex_result_i, ex_pc_i, ex_imm_i, ex_rd_i, ex_rd_we_i, ex_kind_i,
    input  ex_ready_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, wb_we_o,
    output wb_ready_i,
    input  redirect_o, redirect_pc_o
  );

  modport slave (
    input  ex_valid_i, ex_result_i, ex_pc_i, ex_imm_i, ex_rd_i, ex_rd_we_i, ex_kind_i,
    output ex_ready_o,
    output wb_valid_o, wb_rd_o, wb_data_o, wb_we_o,
    input  wb_ready_i,
    output redirect_o, redirect_pc_o
  );

endinterface

// File: rtl/wb_skid_buffer.sv
// Generic 2-entry valid/ready buffer. Output always comes from the main
// entry; the skid entry only catches a push that arrives while main is
// stalled. in_ready is a pure function of registered state.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | no entry held, out_valid=0
// S_ONE   | main entry valid, skid empty
// S_TWO   | main and skid valid, in_ready=0
module wb_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_e;

  occ_e         state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         load_main_in, load_main_skid, load_skid;
  logic         push;

  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign push      = in_valid && in_ready;

  // Occupancy register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // Next occupancy and which register loads from where.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          load_main_in = 1'b1;
          state_d      = S_ONE;
        end
      end
      S_ONE: begin
        if (push && out_ready) begin
          load_main_in = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_d   = S_TWO;
        end else if (out_ready) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_ready) begin
          load_main_skid = 1'b1;
          state_d        = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Payload registers; cleared on reset so the bus reads zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Post-ALU stage: forms writeback entries, resolves branches/jumps and
// issues a one-cycle fetch redirect. Instructions arriving during the
// redirect pulse are on the wrong path: accepted, then dropped.
module ex_wb_stage
  import ex_wb_stage_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  ex_wb_stage_if.slave bus
);

  ex_kind_e        kind;
  wb_entry_t       entry;
  wb_entry_t       out_entry;
  logic [XLEN-1:0] target;
  logic            taken;
  logic            in_ready;
  logic            accept;
  logic            keep;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic [WB_ENTRY_W-1:0] out_bits;

  assign kind   = ex_kind_e'(bus.ex_kind_i);
  assign accept = bus.ex_valid_i && in_ready;
  assign keep   = accept && !redirect_q;

  // Decode the instruction class into a writeback entry and a control-flow target.
  always_comb begin
    entry.rd   = bus.ex_rd_i;
    entry.data = bus.ex_result_i;
    entry.we   = bus.ex_rd_we_i && (bus.ex_rd_i != '0);
    target     = bus.ex_pc_i + bus.ex_imm_i;
    taken      = 1'b0;
    case (kind)
      KIND_BRANCH: begin
        entry.data = '0;
        entry.we   = 1'b0;
        taken      = bus.ex_result_i[0];
      end
      KIND_JAL: begin
        entry.data = link_addr(bus.ex_pc_i);
        taken      = 1'b1;
      end
      KIND_JALR: begin
        entry.data = link_addr(bus.ex_pc_i);
        target     = bus.ex_result_i & ~XLEN'(1);
        taken      = 1'b1;
      end
      default: ;
    endcase
  end

  // Redirect pulse lasts exactly one cycle after a kept taken instruction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= keep && taken;
      if (keep && taken) redirect_pc_q <= target;
    end
  end

  wb_skid_buffer #(
    .W (WB_ENTRY_W)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (keep),
    .in_ready  (in_ready),
    .in_data   (entry),
    .out_valid (bus.wb_valid_o),
    .out_ready (bus.wb_ready_i),
    .out_data  (out_bits)
  );

  assign out_entry         = out_bits;
  assign bus.ex_ready_o    = in_ready;
  assign bus.wb_rd_o       = out_entry.rd;
  assign bus.wb_data_o     = out_entry.data;
  assign bus.wb_we_o       = out_entry.we;
  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: each task drives one scenario and checks inline.
module tb_ex_wb_stage;
  import ex_wb_stage_pkg::*;

  logic clk_i;
  logic rst_i;
  int   tests;
  int   fails;

  ex_wb_stage_if bus ();

  ex_wb_stage u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] kind, input logic [31:0] result,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rd, input logic we);
    bus.ex_valid_i  = 1'b1;
    bus.ex_kind_i   = kind;
    bus.ex_result_i = result;
    bus.ex_pc_i     = pc;
    bus.ex_imm_i    = imm;
    bus.ex_rd_i     = rd;
    bus.ex_rd_we_i  = we;
  endtask

  task automatic idle();
    bus.ex_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    tests++; if (bus.wb_valid_o !== 1'b0) begin fails++; $display("FAIL rst_wb_valid got %0b want 0", bus.wb_valid_o); end
    tests++; if (bus.redirect_o !== 1'b0) begin fails++; $display("FAIL rst_redirect got %0b want 0", bus.redirect_o); end
    tests++; if (bus.wb_data_o !== 32'h0) begin fails++; $display("FAIL rst_wb_data got %h want 0", bus.wb_data_o); end
    tests++; if (bus.redirect_pc_o !== 32'h0) begin fails++; $display("FAIL rst_redirect_pc got %h want 0", bus.redirect_pc_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    tests++; if (bus.ex_ready_o !== 1'b1) begin fails++; $display("FAIL rst_ex_ready got %0b want 1", bus.ex_ready_o); end
    tests++; if (bus.wb_valid_o !== 1'b0) begin fails++; $display("FAIL rst_idle_valid got %0b want 0", bus.wb_valid_o); end
  endtask

  task automatic test_alu();
    bus.wb_ready_i = 1'b1;
    drive(2'd0, 32'h0000_0007, 32'h0, 32'h0, 5'd5, 1'b1);
    tick();
    idle();
    tests++; if (bus.wb_valid_o !== 1'b1) begin fails++; $display("FAIL alu_valid got %0b want 1", bus.wb_valid_o); end
    tests++; if (bus.wb_rd_o !== 5'd5) begin fails++; $display("FAIL alu_rd got %0d want 5", bus.wb_rd_o); end
    tests++; if (bus.wb_data_o !== 32'h7) begin fails++; $display("FAIL alu_data got %h want 7", bus.wb_data_o); end
    tests++; if (bus.wb_we_o !== 1'b1) begin fails++; $display("FAIL alu_we got %0b want 1", bus.wb_we_o); end
    tests++; if (bus.redirect_o !== 1'b0) begin fails++; $display("FAIL alu_redirect got %0b want 0", bus.redirect_o); end
    tick();
    tests++; if (bus.wb_valid_o !== 1'b0) begin fails++; $display("FAIL alu_drain got %0b want 0", bus.wb_valid_o); end
  endtask

  task automatic test_branch();
    bus.wb_ready_i = 1'b1;
    drive(2'd1, 32'h1, 32'h100, 32'hFFFF_FFF0, 5'd0, 1'b0);
    tick();
    idle();
    tests++; if (bus.redirect_o !== 1'b1) begin fails++; $display("FAIL br_taken_redirect got %0b want 1", bus.redirect_o); end
    tests++; if (bus.redirect_pc_o !== 32'h0F0) begin fails++; $display("FAIL br_target got %h want 000000f0", bus.redirect_pc_o); end
    tests++; if (bus.wb_valid_o !== 1'b1) begin fails++; $display("FAIL br_slot_valid got %0b want 1", bus.wb_valid_o); end
    tests++; if (bus.wb_we_o !== 1'b0) begin fails++; $display("FAIL br_we got %0b want 0", bus.wb_we_o); end
    tick();
    tests++; if (bus.redirect_o !== 1'b0) begin fails++; $display("FAIL br_pulse_width got %0b want 0", bus.redirect_o); end
    drive(2'd1, 32'h0, 32'h100, 32'hFFFF_FFF0, 5'd7, 1'b1);
    tick();
    idle();
    tests++; if (bus.redirect_o !== 1'b0) begin fails++; $display("FAIL br_not_taken got %0b want 0", bus.redirect_o); end
    tests++; if (bus.wb_we_o !== 1'b0) begin fails++; $display("FAIL br_nt_we got %0b want 0", bus.wb_we_o); end
    tick();
  endtask

  task automatic test_jumps();
    bus.wb_ready_i = 1'b1;
    drive(2'd3, 32'h0000_2003, 32'h200, 32'h0, 5'd1, 1'b1);
    tick();
    idle();
    tests++; if (bus.redirect_o !== 1'b1) begin fails++; $display("FAIL jalr_redirect got %0b want 1", bus.redirect_o); end
    tests++; if (bus.redirect_pc_o !== 32'h2002) begin fails++; $display("FAIL jalr_target got %h want 00002002", bus.redirect_pc_o); end
    tests++; if (bus.wb_data_o !== 32'h204) begin fails++; $display("FAIL jalr_link got %h want 00000204", bus.wb_data_o); end
    tests++; if (bus.wb_rd_o !== 5'd1 || bus.wb_we_o !== 1'b1) begin fails++; $display("FAIL jalr_rd_we got %0d/%0b want 1/1", bus.wb_rd_o, bus.wb_we_o); end
    tick();
    drive(2'd2, 32'h0, 32'hFFFF_FFFC, 32'h8, 5'd2, 1'b1);
    tick();
    idle();
    tests++; if (bus.wb_data_o !== 32'h0) begin fails++; $display("FAIL jal_link_wrap got %h want 00000000", bus.wb_data_o); end
    tests++; if (bus.redirect_pc_o !== 32'h4) begin fails++; $display("FAIL jal_target_wrap got %h want 00000004", bus.redirect_pc_o); end
    tick();
  endtask

  task automatic test_backpressure();
    bus.wb_ready_i = 1'b0;
    drive(2'd0, 32'hA, 32'h0, 32'h0, 5'd10, 1'b1);
    tick();
    drive(2'd0, 32'hB, 32'h0, 32'h0, 5'd11, 1'b1);
    tests++; if (bus.ex_ready_o !== 1'b1) begin fails++; $display("FAIL bp_ready_one got %0b want 1", bus.ex_ready_o); end
    tick();
    idle();
    tests++; if (bus.ex_ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready_full got %0b want 0", bus.ex_ready_o); end
    tests++; if (bus.wb_rd_o !== 5'd10 || bus.wb_data_o !== 32'hA) begin fails++; $display("FAIL bp_head_a got rd%0d/%h want rd10/0000000a", bus.wb_rd_o, bus.wb_data_o); end
    tick();
    tests++; if (bus.wb_valid_o !== 1'b1 || bus.wb_data_o !== 32'hA) begin fails++; $display("FAIL bp_hold got %0b/%h want 1/0000000a", bus.wb_valid_o, bus.wb_data_o); end
    bus.wb_ready_i = 1'b1;
    tick();
    tests++; if (bus.wb_rd_o !== 5'd11 || bus.wb_data_o !== 32'hB) begin fails++; $display("FAIL bp_head_b got rd%0d/%h want rd11/0000000b", bus.wb_rd_o, bus.wb_data_o); end
    tests++; if (bus.ex_ready_o !== 1'b1) begin fails++; $display("FAIL bp_ready_drain got %0b want 1", bus.ex_ready_o); end
    tick();
    tests++; if (bus.wb_valid_o !== 1'b0) begin fails++; $display("FAIL bp_empty got %0b want 0", bus.wb_valid_o); end
  endtask

  task automatic test_wrong_path();
    bus.wb_ready_i = 1'b1;
    drive(2'd1, 32'h1, 32'h300, 32'h10, 5'd0, 1'b0);
    tick();
    drive(2'd0, 32'h33, 32'h0, 32'h0, 5'd3, 1'b1);
    tests++; if (bus.redirect_o !== 1'b1 || bus.ex_ready_o !== 1'b1) begin fails++; $display("FAIL wp_shadow_cycle got %0b/%0b want 1/1", bus.redirect_o, bus.ex_ready_o); end
    tick();
    idle();
    tests++; if (bus.wb_valid_o !== 1'b0) begin fails++; $display("FAIL wp_dropped got valid %0b rd %0d want 0", bus.wb_valid_o, bus.wb_rd_o); end
    tests++; if (bus.redirect_o !== 1'b0) begin fails++; $display("FAIL wp_no_redirect got %0b want 0", bus.redirect_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.wb_ready_i = 1'b1;
    drive(2'd0, 32'h1111, 32'h0, 32'h0, 5'd20, 1'b1);
    tick();
    drive(2'd0, 32'h2222, 32'h0, 32'h0, 5'd0, 1'b1);
    tests++; if (bus.wb_data_o !== 32'h1111 || bus.wb_we_o !== 1'b1) begin fails++; $display("FAIL b2b_0 got %h/%0b want 00001111/1", bus.wb_data_o, bus.wb_we_o); end
    tick();
    drive(2'd0, 32'h3333, 32'h0, 32'h0, 5'd21, 1'b0);
    tests++; if (bus.wb_data_o !== 32'h2222 || bus.wb_we_o !== 1'b0) begin fails++; $display("FAIL b2b_1_rd0 got %h/%0b want 00002222/0", bus.wb_data_o, bus.wb_we_o); end
    tick();
    idle();
    tests++; if (bus.wb_valid_o !== 1'b1 || bus.wb_data_o !== 32'h3333 || bus.wb_we_o !== 1'b0) begin fails++; $display("FAIL b2b_2 got %0b/%h/%0b want 1/00003333/0", bus.wb_valid_o, bus.wb_data_o, bus.wb_we_o); end
    tests++; if (bus.ex_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready got %0b want 1", bus.ex_ready_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.wb_ready_i = 1'b0;
    drive(2'd0, 32'h55, 32'h0, 32'h0, 5'd9, 1'b1);
    tick();
    drive(2'd2, 32'h0, 32'h40, 32'h20, 5'd0, 1'b0);
    tick();
    idle();
    tests++; if (bus.redirect_o !== 1'b1 || bus.ex_ready_o !== 1'b0) begin fails++; $display("FAIL rm_setup got %0b/%0b want 1/0", bus.redirect_o, bus.ex_ready_o); end
    #2;
    rst_i = 1'b1;
    #1;
    tests++; if (bus.wb_valid_o !== 1'b0 || bus.redirect_o !== 1'b0) begin fails++; $display("FAIL rm_async got %0b/%0b want 0/0", bus.wb_valid_o, bus.redirect_o); end
    tests++; if (bus.wb_data_o !== 32'h0 || bus.wb_rd_o !== 5'd0 || bus.wb_we_o !== 1'b0) begin fails++; $display("FAIL rm_bus_clear got %h/%0d/%0b want 0/0/0", bus.wb_data_o, bus.wb_rd_o, bus.wb_we_o); end
    tick();
    tests++; if (bus.wb_valid_o !== 1'b0 || bus.redirect_pc_o !== 32'h0) begin fails++; $display("FAIL rm_held got %0b/%h want 0/0", bus.wb_valid_o, bus.redirect_pc_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    tests++; if (bus.ex_ready_o !== 1'b1) begin fails++; $display("FAIL rm_ready got %0b want 1", bus.ex_ready_o); end
    bus.wb_ready_i = 1'b1;
    tick();
    tests++; if (bus.wb_valid_o !== 1'b0 || bus.redirect_o !== 1'b0) begin fails++; $display("FAIL rm_quiet got %0b/%0b want 0/0", bus.wb_valid_o, bus.redirect_o); end
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    rst_i           = 1'b1;
    bus.ex_valid_i  = 1'b0;
    bus.ex_kind_i   = 2'd0;
    bus.ex_result_i = 32'h0;
    bus.ex_pc_i     = 32'h0;
    bus.ex_imm_i    = 32'h0;
    bus.ex_rd_i     = 5'd0;
    bus.ex_rd_we_i  = 1'b0;
    bus.wb_ready_i  = 1'b1;

    test_reset();
    test_alu();
    test_branch();
    test_jumps();
    test_backpressure();
    test_wrong_path();
    test_back_to_back();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
